serializer_param: RTL and testbench

Parametrised successor serializer: captures a parallel word of DATA_W bits with a per-word length and bit order, then shifts it out one bit per clock with a qualifying valid strobe. Sits between a word-oriented producer and a single-bit link, and replaces the fixed 16-bit serializer in new designs. It adds a valid/ready input handshake, a registered input word, selectable bit order, and optional back-to-back operation through a one-entry preload buffer.

---
 rtl/serializer_pkg.sv | 24 ++
 rtl/serializer_param_if.sv | 25 ++
 rtl/serializer_param_preload_buf.sv | 27 ++
 rtl/serializer_param.sv | 120 ++++++++++++
 tb/tb_serializer_param.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/serializer_pkg.sv
// Shared types and helpers for the parametrised serializer.
package serializer_pkg;

  localparam int unsigned DEF_DATA_W = 16;
  localparam int unsigned DEF_CNT_W  = $clog2(DEF_DATA_W) + 1;

  typedef enum logic {
    IDLE_S  = 1'b0,
    SHIFT_S = 1'b1
  } state_t;

  // Captured word: payload, decoded length (counts up to DATA_W) and bit order.
  typedef struct packed {
    logic [DEF_DATA_W-1:0] data;
    logic [DEF_CNT_W-1:0]  len;
    logic                  msb_first;
  } word_t;

  // A length field of zero stands for a full-width word.
  function automatic int unsigned decode_len(input int unsigned mod, input int unsigned data_w);
    return (mod == 0) ? data_w : mod;
  endfunction

endpackage

// File: rtl/serializer_param_if.sv
// Word-side valid/ready handshake between a producer and serializer_param.
interface serializer_param_if #(
  parameter int unsigned DATA_W = 16
);
  import serializer_pkg::*;

  localparam int unsigned LEN_W = $clog2(DATA_W);

  logic [DATA_W-1:0] data_i;
  logic [LEN_W-1:0]  mod_i;
  logic              msb_first_i;
  logic              data_val_i;
  logic              ready_o;

  modport master (
    output data_i, mod_i, msb_first_i, data_val_i,
    input  ready_o
  );

  modport slave (
    input  data_i, mod_i, msb_first_i, data_val_i,
    output ready_o
  );

endinterface

// File: rtl/serializer_param_preload_buf.sv
// One-entry holding register for the word queued behind the one being shifted.
module ser_preload_buf #(
  parameter type word_t_p = serializer_pkg::word_t
) (
  input  logic    clk_i,
  input  logic    arst_n_i,
  input  logic    push,
  input  word_t_p wr_word,
  input  logic    pop,
  output logic    full,
  output word_t_p rd_word
);

  // Fill on push, empty on pop; never both in one cycle.
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      full    <= 1'b0;
      rd_word <= '0;
    end else if (push) begin
      full    <= 1'b1;
      rd_word <= wr_word;
    end else if (pop) begin
      full    <= 1'b0;
    end
  end

endmodule

// File: rtl/serializer_param.sv
// Parallel-to-serial converter with per-word length and bit order.
// Build option: SERIALIZER_PRELOAD_EN adds a one-entry preload buffer so
// consecutive words are emitted without an idle cycle between them.
module serializer_param
  import serializer_pkg::*;
#(
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned MIN_LEN = 3
) (
  input  logic              clk_i,
  input  logic              arst_n_i,
  serializer_param_if.slave in_if,
  output logic              ser_data_o,
  output logic              ser_data_val_o,
  output logic              busy_o,
  output logic              drop_o
);

  localparam int unsigned LEN_W = $clog2(DATA_W);
  localparam int unsigned CNT_W = LEN_W + 1;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [CNT_W-1:0]  len;
    logic              msb_first;
  } word_p_t;

  state_t            state_q, state_d;
  word_p_t           in_word_c, next_word_c;
  logic [DATA_W-1:0] ordered_c, sr_q;
  logic [CNT_W-1:0]  len_q, bit_cnt_q;
  logic              ready_en_q, drop_q;
  logic              accept_c, len_ok_c, take_c, load_c, last_bit_c;

  assign in_word_c = '{data:      in_if.data_i,
                       len:       CNT_W'(decode_len(32'(in_if.mod_i), DATA_W)),
                       msb_first: in_if.msb_first_i};

  assign accept_c   = in_if.data_val_i && in_if.ready_o;
  assign len_ok_c   = in_word_c.len >= CNT_W'(MIN_LEN);
  assign take_c     = accept_c && len_ok_c;
  assign last_bit_c = (state_q == SHIFT_S) && (bit_cnt_q == len_q - CNT_W'(1));

`ifdef SERIALIZER_PRELOAD_EN
  logic    buf_full, buf_push_c, buf_pop_c, direct_load_c;
  word_p_t buf_word;

  // An accept goes straight to the shifter when it is idle or finishing.
  assign direct_load_c  = take_c && ((state_q == IDLE_S) || last_bit_c);
  assign buf_push_c     = take_c && !direct_load_c;
  assign buf_pop_c      = last_bit_c && buf_full;
  assign load_c         = direct_load_c || buf_pop_c;
  assign next_word_c    = buf_full ? buf_word : in_word_c;
  assign in_if.ready_o  = ready_en_q && !buf_full;

  ser_preload_buf #(.word_t_p(word_p_t)) u_preload_buf (
    .clk_i    (clk_i),
    .arst_n_i (arst_n_i),
    .push     (buf_push_c),
    .wr_word  (in_word_c),
    .pop      (buf_pop_c),
    .full     (buf_full),
    .rd_word  (buf_word)
  );
`else
  assign load_c         = take_c;
  assign next_word_c    = in_word_c;
  assign in_if.ready_o  = ready_en_q && (state_q == IDLE_S);
`endif

  // Arrange the word so the first bit to send sits at the MSB of the shifter.
  assign ordered_c = next_word_c.msb_first ? next_word_c.data : {<<{next_word_c.data}};

  // State register.
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) state_q <= IDLE_S;
    else           state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE_S:  if (load_c) state_d = SHIFT_S;
      SHIFT_S: if (last_bit_c && !load_c) state_d = IDLE_S;
      default: state_d = IDLE_S;
    endcase
  end

  // Shifter, bit counter, ready enable and drop pulse; shifter is zero when idle.
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      sr_q       <= '0;
      len_q      <= '0;
      bit_cnt_q  <= '0;
      ready_en_q <= 1'b0;
      drop_q     <= 1'b0;
    end else begin
      ready_en_q <= 1'b1;
      drop_q     <= accept_c && !len_ok_c;
      if (load_c) begin
        sr_q      <= ordered_c;
        len_q     <= next_word_c.len;
        bit_cnt_q <= '0;
      end else if (last_bit_c) begin
        sr_q      <= '0;
        bit_cnt_q <= '0;
      end else if (state_q == SHIFT_S) begin
        sr_q      <= sr_q << 1;
        bit_cnt_q <= bit_cnt_q + CNT_W'(1);
      end
    end
  end

  assign ser_data_o     = sr_q[DATA_W-1];
  assign ser_data_val_o = (state_q == SHIFT_S);
  assign busy_o         = (state_q == SHIFT_S);
  assign drop_o         = drop_q;

endmodule

// File: tb/tb_serializer_param.sv
// Self-checking bench for serializer_param against a bit-queue reference model.
module tb_serializer_param;

  localparam int unsigned W       = 16;
  localparam int unsigned W32     = 32;
  localparam int unsigned MIN_LEN = 3;

  logic clk_i    = 1'b0;
  logic arst_n_i = 1'b0;
  always #5 clk_i = ~clk_i;

  serializer_param_if #(.DATA_W(W))   if16();
  serializer_param_if #(.DATA_W(W32)) if32();

  logic ser16, val16, busy16, drop16;
  logic ser32, val32, busy32, drop32;

  serializer_param #(.DATA_W(W), .MIN_LEN(MIN_LEN)) u_dut (
    .clk_i          (clk_i),
    .arst_n_i       (arst_n_i),
    .in_if          (if16),
    .ser_data_o     (ser16),
    .ser_data_val_o (val16),
    .busy_o         (busy16),
    .drop_o         (drop16)
  );

  serializer_param #(.DATA_W(W32), .MIN_LEN(MIN_LEN)) u_dut32 (
    .clk_i          (clk_i),
    .arst_n_i       (arst_n_i),
    .in_if          (if32),
    .ser_data_o     (ser32),
    .ser_data_val_o (val32),
    .busy_o         (busy32),
    .drop_o         (drop32)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: bits still to be sent, and remaining bit count per accepted word.
  bit q_bits[$];
  int q_lens[$];
  bit m_live;
  bit m_drop;
  bit last_acc;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic m_reset();
    q_bits.delete();
    q_lens.delete();
    m_live = 1'b0;
    m_drop = 1'b0;
  endtask

  // Without the buffer a word is taken only when nothing is in flight;
  // with it, one extra word may wait behind the one being sent.
  function automatic bit m_ready();
    if (!m_live) return 1'b0;
`ifdef SERIALIZER_PRELOAD_EN
    return q_lens.size() <= 1;
`else
    return q_lens.size() == 0;
`endif
  endfunction

  task automatic m_update(input bit acc, input logic [W-1:0] d, input logic [3:0] md, input bit msb);
    int len;
    if (!arst_n_i) begin
      m_reset();
      return;
    end
    if (q_bits.size() != 0) begin
      void'(q_bits.pop_front());
      q_lens[0] = q_lens[0] - 1;
      if (q_lens[0] == 0) void'(q_lens.pop_front());
    end
    m_drop = 1'b0;
    if (acc) begin
      len = (md == 4'd0) ? int'(W) : int'(md);
      if (len < int'(MIN_LEN)) begin
        m_drop = 1'b1;
      end else begin
        for (int i = 0; i < len; i++) q_bits.push_back(msb ? d[int'(W) - 1 - i] : d[i]);
        q_lens.push_back(len);
      end
    end
    m_live = 1'b1;
  endtask

  // One clock: compare outputs mid-cycle, then advance the model at the edge.
  task automatic step();
    bit             acc;
    bit             busy_exp;
    logic [W-1:0]   d;
    logic [3:0]     md;
    bit             msb;
    @(negedge clk_i);
    busy_exp = (q_bits.size() != 0);
    check_eq("ser_val",  32'(val16),  32'(busy_exp));
    check_eq("busy",     32'(busy16), 32'(busy_exp));
    check_eq("ser_data", 32'(ser16),  32'(busy_exp ? q_bits[0] : 1'b0));
    check_eq("drop",     32'(drop16), 32'(m_drop));
    check_eq("ready",    32'(if16.ready_o), 32'(m_ready()));
    acc = if16.data_val_i && m_ready();
    d   = if16.data_i;
    md  = if16.mod_i;
    msb = if16.msb_first_i;
    @(posedge clk_i);
    m_update(acc, d, md, msb);
    last_acc = acc;
    #1;
  endtask

  task automatic send_word(input logic [W-1:0] d, input logic [3:0] md, input bit msb, input bit keep);
    if16.data_i      = d;
    if16.mod_i       = md;
    if16.msb_first_i = msb;
    if16.data_val_i  = 1'b1;
    last_acc = 1'b0;
    for (int k = 0; k < 64 && !last_acc; k++) step();
    check_eq("accept", 32'(last_acc), 32'd1);
    if (!keep) begin
      if16.data_val_i = 1'b0;
      if16.data_i     = 16'hFFFF;
    end
  endtask

  task automatic idle(input int n);
    if16.data_val_i = 1'b0;
    for (int k = 0; k < n; k++) begin
      if16.data_i = 16'($urandom);
      if16.mod_i  = 4'($urandom);
      step();
    end
  endtask

  initial begin
    logic [31:0] w32;
    if16.data_i = '0; if16.mod_i = '0; if16.msb_first_i = 1'b0; if16.data_val_i = 1'b0;
    if32.data_i = '0; if32.mod_i = '0; if32.msb_first_i = 1'b0; if32.data_val_i = 1'b0;
    m_reset();

    // Reset values while reset is held.
    #2;
    check_eq("rst_ser",    32'(ser16),  32'd0);
    check_eq("rst_val",    32'(val16),  32'd0);
    check_eq("rst_busy",   32'(busy16), 32'd0);
    check_eq("rst_drop",   32'(drop16), 32'd0);
    check_eq("rst_ready",  32'(if16.ready_o), 32'd0);
    check_eq("rst_ready32", 32'(if32.ready_o), 32'd0);
    repeat (2) @(posedge clk_i);
    #1 arst_n_i = 1'b1;
    idle(2);

    // Full-width MSB-first word.
    send_word(16'hA5C3, 4'd0, 1'b1, 1'b0);
    idle(18);
    // Five-bit LSB-first word; data bus changes right after the accept.
    send_word(16'h0016, 4'd5, 1'b0, 1'b0);
    idle(7);
    // Too-short word is dropped.
    send_word(16'h1234, 4'd2, 1'b1, 1'b0);
    idle(3);
    // Two words with valid held high.
    send_word(16'h000A, 4'd4, 1'b1, 1'b1);
    send_word(16'hABCD, 4'd3, 1'b0, 1'b0);
    idle(10);

    // Reset during bit 6 of a full word, then a fresh 4-bit word.
    send_word(16'hC3A5, 4'd0, 1'b1, 1'b0);
    repeat (6) step();
    #1 arst_n_i = 1'b0;
    #1;
    check_eq("mid_rst_ser",   32'(ser16),  32'd0);
    check_eq("mid_rst_val",   32'(val16),  32'd0);
    check_eq("mid_rst_busy",  32'(busy16), 32'd0);
    check_eq("mid_rst_ready", 32'(if16.ready_o), 32'd0);
    m_reset();
    step();
    step();
    arst_n_i = 1'b1;
    send_word(16'h0009, 4'd4, 1'b1, 1'b0);
    idle(6);

    // Randomized words, lengths, orders and gaps.
    for (int n = 0; n < 300; n++) begin
      logic [3:0] md;
      bit keep;
      md = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(1, 3)) : 4'($urandom_range(0, 15));
      keep = 1'($urandom_range(0, 1));
      send_word(16'($urandom), md, 1'($urandom_range(0, 1)), keep);
      if (!keep) idle($urandom_range(0, 2));
    end
    idle(20);

    // 32-bit instance: full-width word needs the counter to reach 32.
    w32 = 32'h8000_0001;
    if32.data_i      = w32;
    if32.mod_i       = '0;
    if32.msb_first_i = 1'b1;
    if32.data_val_i  = 1'b1;
    @(negedge clk_i);
    check_eq("w32_ready", 32'(if32.ready_o), 32'd1);
    @(posedge clk_i);
    #1;
    if32.data_val_i = 1'b0;
    if32.data_i     = '0;
    for (int i = 0; i < 32; i++) begin
      @(negedge clk_i);
      check_eq("w32_val", 32'(val32), 32'd1);
      check_eq("w32_bit", 32'(ser32), 32'(w32[31 - i]));
    end
    @(negedge clk_i);
    check_eq("w32_end_val",   32'(val32),  32'd0);
    check_eq("w32_end_busy",  32'(busy32), 32'd0);
    check_eq("w32_end_ready", 32'(if32.ready_o), 32'd1);
    check_eq("w32_drop",      32'(drop32), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
